// File: rtl/mod_pkg.sv
// Shared mode codes and FSM state encoding for the modulation engine.
package mod_pkg;

    localparam logic [2:0] MODE_SUM  = 3'b000;
    localparam logic [2:0] MODE_AM   = 3'b001;
    localparam logic [2:0] MODE_XOR  = 3'b010;
    localparam logic [2:0] MODE_ABSD = 3'b011;
    localparam logic [2:0] MODE_PASS = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        MUL  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_mult.sv
// Unsigned shift-add multiplier: one partial product per clock, M steps total.
module seq_mult #(
    parameter int M = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    output logic           done,
    output logic [2*M-1:0] product
);

    localparam int CW = $clog2(M + 1);

    logic [2*M-1:0] acc;
    logic [2*M-1:0] mcand;
    logic [M-1:0]   mplier;
    logic [CW-1:0]  remaining;
    logic           running;

    // The start edge already folds in bit 0, so M-1 further steps finish the product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            remaining <= '0;
            running   <= 1'b0;
        end else if (start) begin
            acc       <= b[0] ? {{M{1'b0}}, a} : '0;
            mcand     <= {{M{1'b0}}, a} << 1;
            mplier    <= b >> 1;
            remaining <= CW'(M - 1);
            running   <= 1'b1;
        end else if (running) begin
            if (remaining == '0) begin
                running <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand     <= mcand << 1;
                mplier    <= mplier >> 1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    assign done    = running && (remaining == '0);
    assign product = acc;

endmodule

// File: rtl/mod_engine.sv
// Sequential two-oscillator modulation stage: sum, AM, XOR, |a-b| or passthrough,
// delivered as a registered, left-justified word with a one-cycle valid pulse.
module mod_engine
    import mod_pkg::*;
#(
    parameter int M = 12,
    parameter int O = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sampleEn,
    input  logic [M-1:0] osc0,
    input  logic [M-1:0] osc1,
    input  logic [2:0]   modSel,
    output logic [O-1:0] modOut,
    output logic         modValid,
    output logic         busy,
    output logic         overrun
);

    generate
        if (M < 2 || O < M + 1 || O > 2 * M) begin : g_bad_params
            $error("mod_engine: illegal parameters, need M >= 2 and M+1 <= O <= 2M");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic [M-1:0]     a_r;
    logic [M-1:0]     b_r;
    logic [2:0]       mode_r;
    logic             accept;
    logic             write_out;
    logic             mult_start;
    logic             mult_done;
    logic [2*M-1:0]   product;
    logic [M:0]       sum_w;
    logic [M-1:0]     absd_w;
    logic [O-1:0]     result;

    seq_mult #(.M(M)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mult_start),
        .a       (osc0),
        .b       (osc1),
        .done    (mult_done),
        .product (product)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        write_out  = 1'b0;
        mult_start = 1'b0;
        case (state)
            IDLE: begin
                if (sampleEn) begin
                    accept = 1'b1;
                    if (modSel == MODE_AM) begin
                        mult_start = 1'b1;
                        state_next = MUL;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                write_out  = 1'b1;
                state_next = IDLE;
            end
            MUL: begin
                if (mult_done) begin
                    write_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are left-justified into O bits; the SUM carry lands in the MSB.
    always_comb begin
        sum_w  = {1'b0, a_r} + {1'b0, b_r};
        absd_w = (a_r > b_r) ? (a_r - b_r) : (b_r - a_r);
        case (mode_r)
            MODE_SUM:  result = O'(sum_w) << (O - M - 1);
            MODE_AM:   result = product[2*M-1 -: O];
            MODE_XOR:  result = O'(a_r ^ b_r) << (O - M);
            MODE_ABSD: result = O'(absd_w) << (O - M);
            default:   result = O'(a_r) << (O - M);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            mode_r   <= MODE_PASS;
            modOut   <= '0;
            modValid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_next;
            modValid <= write_out;
            overrun  <= sampleEn && (state != IDLE);
            if (accept) begin
                a_r    <= osc0;
                b_r    <= osc1;
                mode_r <= modSel;
            end
            if (write_out) begin
                modOut <= result;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mod_engine.sv
// Self-checking bench for mod_engine: constant vectors, hand-built corner sequences
// and randomized samples against an arithmetic reference model.
module tb_mod_engine;

    localparam int M = 12;
    localparam int O = 16;

    logic         clk;
    logic         rst_n;
    logic         sampleEn;
    logic [M-1:0] osc0;
    logic [M-1:0] osc1;
    logic [2:0]   modSel;
    logic [O-1:0] modOut;
    logic         modValid;
    logic         busy;
    logic         overrun;

    int total;
    int bad;

    typedef struct {
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [2:0]   sel;
        logic [O-1:0] expect_out;
    } vec_t;

    vec_t vecs[10];

    mod_engine #(.M(M), .O(O)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sampleEn (sampleEn),
        .osc0     (osc0),
        .osc1     (osc1),
        .modSel   (modSel),
        .modOut   (modOut),
        .modValid (modValid),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: plain integer arithmetic on the full-precision result, then justified.
    function automatic logic [O-1:0] ref_model(input int unsigned a, input int unsigned b, input int unsigned sel);
        longint unsigned r;
        case (sel)
            0:       r = longint'(a + b) << (O - M - 1);
            1:       r = (longint'(a) * longint'(b)) >> (2 * M - O);
            2:       r = longint'(a ^ b) << (O - M);
            3:       r = longint'((a > b) ? (a - b) : (b - a)) << (O - M);
            default: r = longint'(a) << (O - M);
        endcase
        return r[O-1:0];
    endfunction

    // Called at a negedge with the engine idle; returns at the negedge where modValid is seen.
    task automatic apply_stimulus(input logic [M-1:0] a, input logic [M-1:0] b, input logic [2:0] sel,
                                  input logic [O-1:0] expect_out, input string name);
        int n;
        int lat;
        lat      = (sel == 3'b001) ? M : 1;
        sampleEn = 1'b1;
        osc0     = a;
        osc1     = b;
        modSel   = sel;
        step();
        sampleEn = 1'b0;
        osc0     = M'($urandom);
        osc1     = M'($urandom);
        modSel   = 3'($urandom);
        check_output({name, " busy_after_accept"}, 32'(busy), 32'd1);
        n = 0;
        while (!modValid && n < 40) begin
            step();
            n++;
        end
        check_output({name, " latency"}, n, lat);
        check_output({name, " modOut"}, 32'(modOut), 32'(expect_out));
        check_output({name, " busy_at_valid"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        sampleEn = 1'b0;
        osc0     = '0;
        osc1     = '0;
        modSel   = '0;

        vecs[0] = '{12'hFFF, 12'h001, 3'b000, 16'h8000};
        vecs[1] = '{12'hFFF, 12'hFFF, 3'b001, 16'hFFE0};
        vecs[2] = '{12'hF0F, 12'h0FF, 3'b010, 16'hFF00};
        vecs[3] = '{12'h100, 12'h300, 3'b011, 16'h2000};
        vecs[4] = '{12'hABC, 12'h123, 3'b101, 16'hABC0};
        vecs[5] = '{12'h300, 12'h100, 3'b011, 16'h2000};
        vecs[6] = '{12'hFFF, 12'hFFF, 3'b000, 16'hFFF0};
        vecs[7] = '{12'h800, 12'h002, 3'b001, 16'h0010};
        vecs[8] = '{12'h001, 12'hFFF, 3'b111, 16'h0010};
        vecs[9] = '{12'h555, 12'h000, 3'b100, 16'h5550};

        repeat (2) @(negedge clk);
        check_output("reset modOut", 32'(modOut), 32'd0);
        check_output("reset modValid", 32'(modValid), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].expect_out, $sformatf("vec%0d", i));
            step();
        end

        // Overrun during AM: the dropped SUM sample must never surface.
        sampleEn = 1'b1; osc0 = 12'h800; osc1 = 12'h002; modSel = 3'b001;
        step();
        sampleEn = 1'b0;
        step();
        step();
        sampleEn = 1'b1; osc0 = 12'h111; osc1 = 12'h222; modSel = 3'b000;
        step();
        sampleEn = 1'b0;
        check_output("ovr pulse", 32'(overrun), 32'd1);
        check_output("ovr no_valid_yet", 32'(modValid), 32'd0);
        step();
        check_output("ovr pulse_ends", 32'(overrun), 32'd0);
        n = 4;
        while (!modValid && n < 40) begin
            step();
            n++;
        end
        check_output("ovr am_latency", n, M);
        check_output("ovr am_result", 32'(modOut), 32'h0010);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (modValid) seen++;
        end
        check_output("ovr dropped_sample", seen, 0);

        // Reset in the middle of an AM: abandoned, no valid pulse.
        sampleEn = 1'b1; osc0 = 12'hFFF; osc1 = 12'hFFF; modSel = 3'b001;
        step();
        sampleEn = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check_output("midrst modOut", 32'(modOut), 32'd0);
        check_output("midrst busy", 32'(busy), 32'd0);
        check_output("midrst modValid", 32'(modValid), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (modValid) seen++;
        end
        check_output("midrst no_valid", seen, 0);
        apply_stimulus(12'h123, 12'h456, 3'b000, 16'h2BC8, "after_reset_sum");
        step();

        // Reset and sampleEn together: reset wins.
        rst_n = 1'b0; sampleEn = 1'b1; osc0 = 12'h321; modSel = 3'b000;
        step();
        rst_n = 1'b1; sampleEn = 1'b0;
        check_output("rst_vs_sample busy", 32'(busy), 32'd0);
        step();
        check_output("rst_vs_sample valid", 32'(modValid), 32'd0);

        // Back-to-back: second sample issued in the modValid cycle.
        seen = 0;
        sampleEn = 1'b1; osc0 = 12'h123; osc1 = 12'h456; modSel = 3'b000;
        step();
        sampleEn = 1'b0;
        if (overrun) seen++;
        step();
        if (overrun) seen++;
        check_output("b2b first_valid", 32'(modValid), 32'd1);
        check_output("b2b first_out", 32'(modOut), 32'h2BC8);
        sampleEn = 1'b1; osc0 = 12'hF0F; osc1 = 12'h0FF; modSel = 3'b010;
        step();
        sampleEn = 1'b0;
        if (overrun) seen++;
        check_output("b2b second_busy", 32'(busy), 32'd1);
        step();
        if (overrun) seen++;
        check_output("b2b second_valid", 32'(modValid), 32'd1);
        check_output("b2b second_out", 32'(modOut), 32'hFF00);
        check_output("b2b no_overrun", seen, 0);
        step();

        // Randomized samples against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [M-1:0] ra;
            logic [M-1:0] rb;
            logic [2:0]   rs;
            ra = M'($urandom);
            rb = M'($urandom);
            rs = 3'($urandom_range(0, 7));
            if (i % 4 == 0) ra = '1;
            apply_stimulus(ra, rb, rs, ref_model(ra, rb, rs), $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
